ftm_recovery_seq: RTL and testbench

Lockstep recovery sequencer for the dual-core fault-tolerant core. It compares the register-file writeback streams of core 0 and core 1 and, on divergence, drives the debug-request line that forces both cores into the recovery routine. It times the routine, escalates to a core reset with bounded retries, and latches a fatal state when recovery keeps failing. It sits beside the FTM checkpoint logic and sequences when the recovery ROM and checkpoint memory are in use.

---
 rtl/ftm_recovery_seq.sv | 180 ++++++++++++++++++
 tb/tb_ftm_recovery_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ftm_recovery_seq.sv
// ftm_recovery_seq: lockstep recovery sequencer for the dual-core FTM.
// Compares the core 0 / core 1 regfile writeback streams. On divergence it
// requests debug-mode recovery, times the recovery routine, escalates to a
// core reset with bounded retries, and latches a fatal state once the
// retries are exhausted.
// Optional build macro FTM_SEQ_PC_CHECK_EN: when defined, a PC difference
// on a cycle where both instruction-valid strobes are high also counts as a
// mismatch.
module ftm_recovery_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES    = 2,
  parameter int unsigned RESET_CYCLES   = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        we_a_i,
  input  logic        we_b_i,
  input  logic [4:0]  addr_a_i,
  input  logic [4:0]  addr_b_i,
  input  logic [31:0] data_a_i,
  input  logic [31:0] data_b_i,
  input  logic [31:0] pc_a_i,
  input  logic [31:0] pc_b_i,
  input  logic        valid_a_i,
  input  logic        valid_b_i,
  input  logic        done_i,
  output logic        recover_o,
  output logic        reset_o,
  output logic        recovering_o,
  output logic        error_o,
  output logic        fail_o,
  output logic [31:0] error_pc_o,
  output logic [3:0]  retry_cnt_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RW = $clog2(RESET_CYCLES + 1);

  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RST_LAST  = RW'(RESET_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RECOVER,
    ST_RESET,
    ST_FAIL
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [RW-1:0] rs_cnt_q, rs_cnt_d;
  logic [3:0]    retry_q, retry_d;
  logic [31:0]   error_pc_q, error_pc_d;
  logic          error_q, error_d;
  logic          recover_q, recover_d;
  logic          recovering_q, recovering_d;
  logic          reset_q, reset_d;
  logic          fail_q, fail_d;

  logic          wb_mismatch;
  logic          pc_mismatch;
  logic          mismatch;

  // Writeback divergence; matching writes to x0 are discarded by both cores.
  always_comb begin
    wb_mismatch = 1'b0;
    if (we_a_i != we_b_i) begin
      wb_mismatch = 1'b1;
    end else if (we_a_i && !((addr_a_i == 5'd0) && (addr_b_i == 5'd0))) begin
      wb_mismatch = (addr_a_i != addr_b_i) || (data_a_i != data_b_i);
    end
  end

`ifdef FTM_SEQ_PC_CHECK_EN
  assign pc_mismatch = valid_a_i && valid_b_i && (pc_a_i != pc_b_i);
`else
  logic unused_pc_check;
  assign unused_pc_check = &{1'b0, pc_b_i, valid_a_i, valid_b_i};
  assign pc_mismatch     = 1'b0;
`endif

  assign mismatch = wb_mismatch || pc_mismatch;

  // Next-state, counters and registered output decode.
  always_comb begin
    state_d    = state_q;
    to_cnt_d   = to_cnt_q;
    rs_cnt_d   = rs_cnt_q;
    retry_d    = retry_q;
    error_pc_d = error_pc_q;
    error_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable_i && mismatch) begin
          state_d    = ST_REQ;
          error_d    = 1'b1;
          error_pc_d = pc_a_i;
        end
      end
      ST_REQ: begin
        to_cnt_d = '0;
        state_d  = ST_RECOVER;
      end
      ST_RECOVER: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (done_i) begin
          state_d = ST_IDLE;
          retry_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
          if (retry_q < RETRY_MAX) begin
            retry_d  = retry_q + 1'b1;
            rs_cnt_d = '0;
            state_d  = ST_RESET;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_RESET: begin
        rs_cnt_d = rs_cnt_q + 1'b1;
        if (rs_cnt_q == RST_LAST) begin
          state_d = ST_REQ;
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they change on the same
    // edge as the state register and come straight out of flops.
    recover_d    = (state_d == ST_REQ) || (state_d == ST_RECOVER);
    recovering_d = (state_d == ST_RECOVER);
    reset_d      = (state_d == ST_RESET) || (state_d == ST_FAIL);
    fail_d       = (state_d == ST_FAIL);
  end

  // State, counters and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      to_cnt_q     <= '0;
      rs_cnt_q     <= '0;
      retry_q      <= '0;
      error_pc_q   <= '0;
      error_q      <= 1'b0;
      recover_q    <= 1'b0;
      recovering_q <= 1'b0;
      reset_q      <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      to_cnt_q     <= to_cnt_d;
      rs_cnt_q     <= rs_cnt_d;
      retry_q      <= retry_d;
      error_pc_q   <= error_pc_d;
      error_q      <= error_d;
      recover_q    <= recover_d;
      recovering_q <= recovering_d;
      reset_q      <= reset_d;
      fail_q       <= fail_d;
    end
  end

  assign recover_o    = recover_q;
  assign reset_o      = reset_q;
  assign recovering_o = recovering_q;
  assign error_o      = error_q;
  assign fail_o       = fail_q;
  assign error_pc_o   = error_pc_q;
  assign retry_cnt_o  = retry_q;

endmodule

// File: tb/tb_ftm_recovery_seq.sv
// tb_ftm_recovery_seq: directed plus randomized stimulus for ftm_recovery_seq,
// checked every cycle against an episode-timeline reference model.
module tb_ftm_recovery_seq;

  localparam int T  = 16;
  localparam int MR = 2;
  localparam int RC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        we_a, we_b;
  logic [4:0]  addr_a, addr_b;
  logic [31:0] data_a, data_b;
  logic [31:0] pc_a, pc_b;
  logic        valid_a, valid_b;
  logic        done;
  logic        recover, reset_out, recovering, error, fail;
  logic [31:0] error_pc;
  logic [3:0]  retry_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: an episode is a sequence of attempts; each attempt is a
  // timeline of 1 request cycle, T recovery cycles and RC reset cycles.
  bit          m_active;
  bit          m_fail;
  int          m_phase;
  int          m_att;
  bit          m_err;
  logic [31:0] m_epc;

  always #5 clk = ~clk;

  ftm_recovery_seq #(
    .TIMEOUT_CYCLES(T),
    .MAX_RETRIES   (MR),
    .RESET_CYCLES  (RC)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .enable_i    (enable),
    .we_a_i      (we_a),
    .we_b_i      (we_b),
    .addr_a_i    (addr_a),
    .addr_b_i    (addr_b),
    .data_a_i    (data_a),
    .data_b_i    (data_b),
    .pc_a_i      (pc_a),
    .pc_b_i      (pc_b),
    .valid_a_i   (valid_a),
    .valid_b_i   (valid_b),
    .done_i      (done),
    .recover_o   (recover),
    .reset_o     (reset_out),
    .recovering_o(recovering),
    .error_o     (error),
    .fail_o      (fail),
    .error_pc_o  (error_pc),
    .retry_cnt_o (retry_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit ref_mismatch();
    bit mm;
    mm = 1'b0;
    if (we_a != we_b) mm = 1'b1;
    else if (we_a && !(addr_a == 5'd0 && addr_b == 5'd0))
      mm = (addr_a != addr_b) || (data_a != data_b);
`ifdef FTM_SEQ_PC_CHECK_EN
    if (valid_a && valid_b && pc_a != pc_b) mm = 1'b1;
`endif
    return mm;
  endfunction

  task automatic model_clear();
    m_active = 1'b0;
    m_fail   = 1'b0;
    m_phase  = 0;
    m_att    = 0;
    m_err    = 1'b0;
    m_epc    = '0;
  endtask

  task automatic model_step();
    m_err = 1'b0;
    if (m_fail) begin
      // held until reset
    end else if (!m_active) begin
      if (enable && ref_mismatch()) begin
        m_active = 1'b1;
        m_phase  = 0;
        m_err    = 1'b1;
        m_epc    = pc_a;
      end
    end else if (m_phase >= 1 && m_phase <= T && done) begin
      m_active = 1'b0;
      m_att    = 0;
    end else if (m_phase == T) begin
      if (m_att < MR) begin
        m_att++;
        m_phase++;
      end else begin
        m_fail   = 1'b1;
        m_active = 1'b0;
      end
    end else if (m_phase == T + RC) begin
      m_phase = 0;
    end else begin
      m_phase++;
    end
  endtask

  task automatic compare_all();
    check_val("error_o",      32'(error),      32'(m_err));
    check_val("recover_o",    32'(recover),    32'(m_active && m_phase <= T));
    check_val("recovering_o", 32'(recovering), 32'(m_active && m_phase >= 1 && m_phase <= T));
    check_val("reset_o",      32'(reset_out),  32'(m_fail || (m_active && m_phase > T)));
    check_val("fail_o",       32'(fail),       32'(m_fail));
    check_val("error_pc_o",   error_pc,        m_epc);
    check_val("retry_cnt_o",  32'(retry_cnt),  32'(m_att));
  endtask

  // One clock: inputs were set after the previous falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_clear();
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_quiet();
    we_a = 0; we_b = 0; addr_a = '0; addr_b = '0; data_a = '0; data_b = '0;
    done = 0; valid_a = 0; valid_b = 0; pc_b = pc_a;
  endtask

  task automatic inject_data_mismatch(input logic [31:0] pc);
    we_a = 1; we_b = 1; addr_a = 5'd3; addr_b = 5'd3;
    data_a = 32'hAAAA; data_b = 32'hAAAB; pc_a = pc; pc_b = pc;
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; pc_a = '0;
    set_quiet();
    @(negedge clk);
    do_reset();

    // Clean lockstep writes, including x0 writes with differing data.
    enable = 1;
    for (int i = 0; i < 100; i++) begin
      we_a = 1; we_b = 1; addr_a = 5'd5; addr_b = 5'd5;
      data_a = 32'h1234; data_b = 32'h1234; pc_a = 32'(i * 4); pc_b = pc_a;
      cycle();
    end
    we_a = 1; we_b = 1; addr_a = '0; addr_b = '0; data_a = 32'h1; data_b = 32'h2;
    cycle();
    check_val("x0_ignored", 32'(error), 32'h0);

    // Data mismatch, then mismatches during recovery must not re-capture.
    inject_data_mismatch(32'h80);
    cycle();
    check_val("dm_error", 32'(error), 32'h1);
    check_val("dm_pc", error_pc, 32'h80);
    set_quiet();
    cycle();
    check_val("dm_error_low", 32'(error), 32'h0);
    check_val("dm_recovering", 32'(recovering), 32'h1);
    for (int i = 0; i < 9; i++) begin
      inject_data_mismatch(32'h999);
      cycle();
    end
    set_quiet();
    check_val("dm_pc_hold", error_pc, 32'h80);
    done = 1;
    cycle();
    done = 0;
    check_val("dm_idle_recover", 32'(recover), 32'h0);
    check_val("dm_retry", 32'(retry_cnt), 32'h0);

    // Timeout with no done: two reset phases, then fatal.
    inject_data_mismatch(32'h200);
    cycle();
    set_quiet();
    for (int i = 0; i < 3 * (T + RC + 1) + 10 && !m_fail; i++) cycle();
    check_val("to_fail", 32'(fail), 32'h1);
    check_val("to_retry", 32'(retry_cnt), 32'(MR));
    for (int i = 0; i < 5; i++) begin
      done = 1; inject_data_mismatch(32'h300);
      cycle();
    end
    set_quiet();
    check_val("fail_hold_reset", 32'(reset_out), 32'h1);
    do_reset();
    check_val("post_fail_rst", 32'(fail), 32'h0);

    // done on the exact timeout cycle wins.
    inject_data_mismatch(32'h400);
    cycle();
    set_quiet();
    for (int i = 0; i < T + 5 && m_phase != T; i++) cycle();
    done = 1;
    cycle();
    done = 0;
    check_val("bnd_reset", 32'(reset_out), 32'h0);
    check_val("bnd_recover", 32'(recover), 32'h0);
    cycle();

    // Masked by enable_i low.
    enable = 0;
    for (int i = 0; i < 20; i++) begin
      inject_data_mismatch(32'h500);
      cycle();
    end
    check_val("mask_error", 32'(recover), 32'h0);
    enable = 1;
    set_quiet();

    // PC-only divergence.
    pc_a = 32'h100; pc_b = 32'h104; valid_a = 1; valid_b = 1;
    cycle();
`ifdef FTM_SEQ_PC_CHECK_EN
    check_val("pc_error", 32'(error), 32'h1);
`else
    check_val("pc_error", 32'(error), 32'h0);
`endif
    set_quiet();
    done = 1;
    for (int i = 0; i < 4 && m_active; i++) cycle();
    done = 0;

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      enable  = ($urandom_range(0, 9) != 0);
      we_a    = $urandom_range(0, 1);
      we_b    = ($urandom_range(0, 49) == 0) ? ~we_a : we_a;
      addr_a  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      addr_b  = ($urandom_range(0, 49) == 0) ? 5'($urandom) : addr_a;
      data_a  = $urandom;
      data_b  = ($urandom_range(0, 29) == 0) ? data_a ^ (32'h1 << $urandom_range(0, 31)) : data_a;
      pc_a    = $urandom;
      pc_b    = ($urandom_range(0, 29) == 0) ? $urandom : pc_a;
      valid_a = $urandom_range(0, 1);
      valid_b = $urandom_range(0, 1);
      done    = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
